// File: rtl/x_mem_arb.sv
// Two-requester arbiter sharing one single-port memory (round-robin or fixed priority).
// Optional wait timeout/abort is enabled with the X_MEM_ARB_TIMEOUT_EN macro.
module x_mem_arb #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_r0_valid,
  input  logic        i_r0_rnw,
  input  logic [31:0] i_r0_addr,
  input  logic [31:0] i_r0_data,
  output logic        o_r0_accept,
  output logic [31:0] o_r0_data,
  input  logic        i_r1_valid,
  input  logic        i_r1_rnw,
  input  logic [31:0] i_r1_addr,
  input  logic [31:0] i_r1_data,
  output logic        o_r1_accept,
  output logic [31:0] o_r1_data,
  output logic        o_m_valid,
  output logic        o_m_rnw,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_data,
  input  logic        i_m_accept,
  input  logic [31:0] i_m_data,
  output logic [1:0]  o_grant,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  req_t   r0_req, r1_req, sel_req;
  logic   sel_valid;
  logic   abort;
  logic   done;

  assign r0_req = {i_r0_rnw, i_r0_addr, i_r0_data};
  assign r1_req = {i_r1_rnw, i_r1_addr, i_r1_data};

  // TIMEOUT must fit the 8-bit wait counter and be nonzero
  assert property (@(posedge i_clk) (TIMEOUT >= 32'd1 && TIMEOUT <= 32'd255));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Request of the currently granted requester
  always_comb begin
    sel_valid = 1'b0;
    sel_req   = '0;
    case (state)
      GNT0: begin
        sel_valid = i_r0_valid;
        sel_req   = r0_req;
      end
      GNT1: begin
        sel_valid = i_r1_valid;
        sel_req   = r1_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    o_m_valid   = 1'b0;
    o_m_rnw     = 1'b0;
    o_m_addr    = '0;
    o_m_data    = '0;
    o_r0_accept = 1'b0;
    o_r0_data   = '0;
    o_r1_accept = 1'b0;
    o_r1_data   = '0;
    o_grant     = 2'b00;
    done        = (i_m_accept & sel_valid) | abort;
    case (state)
      IDLE: begin
        // Tie goes to r0 under fixed priority, otherwise to the one not served last
        if (i_r0_valid && i_r1_valid) begin
          if (FIXED_PRIO != 32'd0 || last) begin
            state_nxt = GNT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = GNT1;
            last_nxt  = 1'b1;
          end
        end else if (i_r0_valid) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (i_r1_valid) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        o_m_valid = sel_valid & ~abort;
        o_m_rnw   = sel_req.rnw;
        o_m_addr  = sel_req.addr;
        o_m_data  = sel_req.data;
        o_grant   = (state == GNT0) ? 2'b01 : 2'b10;
        if (state == GNT0) begin
          o_r0_accept = done;
          o_r0_data   = abort ? '0 : i_m_data;
        end else begin
          o_r1_accept = done;
          o_r1_data   = abort ? '0 : i_m_data;
        end
        if (i_m_accept || !sel_valid || abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef X_MEM_ARB_TIMEOUT_EN
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] err_cnt;

  // A real accept in the timeout cycle takes precedence over the abort
  assign abort = (state != IDLE) && sel_valid && !i_m_accept && (wait_cnt == CW'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (!i_m_accept) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (abort && err_cnt != '1) begin
        err_cnt <= err_cnt + CW'(1);
      end
    end
  end

  assign o_err     = abort;
  assign o_err_cnt = err_cnt;
`else
  assign abort     = 1'b0;
  assign o_err     = 1'b0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_x_mem_arb.sv
// Bench for x_mem_arb: round-robin and fixed-priority instances checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_x_mem_arb;
  localparam int unsigned TO = 4;
`ifdef X_MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rv[2][2], rrnw[2][2];
  logic [31:0] raddr[2][2], rwd[2][2];
  logic acc[2][2];
  logic [31:0] rrd[2][2];
  logic mv[2], mrnw[2];
  logic [31:0] maddr[2], mwd[2];
  logic macc[2];
  logic [31:0] mrd[2];
  logic [1:0] gnt[2];
  logic err[2];
  logic [7:0] ecnt_o[2];

  always #5 clk = ~clk;

  x_mem_arb #(.FIXED_PRIO(0), .TIMEOUT(TO)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_r0_valid(rv[0][0]), .i_r0_rnw(rrnw[0][0]), .i_r0_addr(raddr[0][0]), .i_r0_data(rwd[0][0]),
    .o_r0_accept(acc[0][0]), .o_r0_data(rrd[0][0]),
    .i_r1_valid(rv[0][1]), .i_r1_rnw(rrnw[0][1]), .i_r1_addr(raddr[0][1]), .i_r1_data(rwd[0][1]),
    .o_r1_accept(acc[0][1]), .o_r1_data(rrd[0][1]),
    .o_m_valid(mv[0]), .o_m_rnw(mrnw[0]), .o_m_addr(maddr[0]), .o_m_data(mwd[0]),
    .i_m_accept(macc[0]), .i_m_data(mrd[0]),
    .o_grant(gnt[0]), .o_err(err[0]), .o_err_cnt(ecnt_o[0])
  );

  x_mem_arb #(.FIXED_PRIO(1), .TIMEOUT(TO)) u_fp (
    .i_clk(clk), .i_rst(rst),
    .i_r0_valid(rv[1][0]), .i_r0_rnw(rrnw[1][0]), .i_r0_addr(raddr[1][0]), .i_r0_data(rwd[1][0]),
    .o_r0_accept(acc[1][0]), .o_r0_data(rrd[1][0]),
    .i_r1_valid(rv[1][1]), .i_r1_rnw(rrnw[1][1]), .i_r1_addr(raddr[1][1]), .i_r1_data(rwd[1][1]),
    .o_r1_accept(acc[1][1]), .o_r1_data(rrd[1][1]),
    .o_m_valid(mv[1]), .o_m_rnw(mrnw[1]), .o_m_addr(maddr[1]), .o_m_data(mwd[1]),
    .i_m_accept(macc[1]), .i_m_data(mrd[1]),
    .o_grant(gnt[1]), .o_err(err[1]), .o_err_cnt(ecnt_o[1])
  );

  // Model: who owns the memory (-1 = nobody), who was served last, wait and error counts
  int mg[2], mlast[2], mwc[2], mecnt[2];
  int mcnt[2], mwait[2];
  logic [31:0] mfix[2];
  bit mrand, chk_en;
  logic eacc[2][2];
  int checks = 0, errors = 0;

  logic [1:0] ob_gnt[2];
  logic ob_mv[2], ob_err[2];
  logic ob_acc[2][2];
  logic [31:0] ob_rd[2][2], ob_maddr[2], ob_mwd[2];
  logic [7:0] ob_ecnt[2];
  logic [15:0] hist[2];
  int acc_cnt[2][2];

  task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %h expected %h at %0t", k, name, act, exp, $time);
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(7, 0) == 0) return int'($urandom_range(7, 4));
    return int'($urandom_range(3, 0));
  endfunction

  // One clock cycle: memory responds, outputs are compared, model advances
  task automatic step();
    int x, pick;
    bit abort, req;
    logic e_mv;
    logic [1:0] e_g;
    logic e_acc[2];
    logic [31:0] e_rd[2];
    for (int k = 0; k < 2; k++) begin
      req = 1'b0;
      if (mg[k] >= 0) req = rv[k][mg[k]];
      macc[k] = req && (mcnt[k] == mwait[k]);
      mrd[k]  = mrand ? $urandom : mfix[k];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      x = mg[k];
      e_mv = 1'b0; e_g = 2'b00; abort = 1'b0;
      e_acc[0] = 1'b0; e_acc[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
      req = 1'b0;
      if (x >= 0) begin
        req      = rv[k][x];
        abort    = TO_EN && rv[k][x] && !macc[k] && (mwc[k] == int'(TO));
        e_mv     = rv[k][x] && !abort;
        e_g      = (x == 0) ? 2'b01 : 2'b10;
        e_acc[x] = (macc[k] && rv[k][x]) || abort;
        e_rd[x]  = abort ? 32'h0 : mrd[k];
      end
      if (chk_en) begin
        check(k, "m_valid", 32'(mv[k]), 32'(e_mv));
        check(k, "grant", 32'(gnt[k]), 32'(e_g));
        check(k, "r0_accept", 32'(acc[k][0]), 32'(e_acc[0]));
        check(k, "r1_accept", 32'(acc[k][1]), 32'(e_acc[1]));
        check(k, "r0_data", rrd[k][0], e_rd[0]);
        check(k, "r1_data", rrd[k][1], e_rd[1]);
        check(k, "err", 32'(err[k]), 32'(abort));
        check(k, "err_cnt", 32'(ecnt_o[k]), 32'(mecnt[k]));
        if (x >= 0) begin
          check(k, "m_rnw", 32'(mrnw[k]), 32'(rrnw[k][x]));
          check(k, "m_addr", maddr[k], raddr[k][x]);
          check(k, "m_data", mwd[k], rwd[k][x]);
        end
      end
      ob_gnt[k] = gnt[k]; ob_mv[k] = mv[k]; ob_err[k] = err[k]; ob_ecnt[k] = ecnt_o[k];
      ob_maddr[k] = maddr[k]; ob_mwd[k] = mwd[k];
      for (int r = 0; r < 2; r++) begin
        ob_acc[k][r] = acc[k][r];
        ob_rd[k][r]  = rrd[k][r];
        eacc[k][r]   = e_acc[r];
        if (acc[k][r] === 1'b1) acc_cnt[k][r]++;
      end
      hist[k] = {hist[k][13:0], gnt[k]};
      if (rst) begin
        mg[k] = -1; mlast[k] = 1; mwc[k] = 0; mecnt[k] = 0;
      end else if (x < 0) begin
        pick = -1;
        if (rv[k][0] && rv[k][1]) pick = (k == 1) ? 0 : 1 - mlast[k];
        else if (rv[k][0]) pick = 0;
        else if (rv[k][1]) pick = 1;
        if (pick >= 0) begin
          mg[k] = pick; mlast[k] = pick; mwc[k] = 0;
        end
      end else if (macc[k] || !rv[k][x] || abort) begin
        mg[k] = -1;
        if (abort && mecnt[k] < 255) mecnt[k]++;
      end else begin
        mwc[k]++;
      end
      if (rst || !req || macc[k]) begin
        mcnt[k] = 0;
        if (mrand) mwait[k] = pick_wait();
      end else begin
        mcnt[k]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (rv[k][r]) begin
          if (eacc[k][r] || $urandom_range(47, 0) == 0) rv[k][r] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          rv[k][r]    = 1'b1;
          rrnw[k][r]  = 1'($urandom_range(1, 0));
          raddr[k][r] = $urandom;
          rwd[k][r]   = $urandom;
        end
      end
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        rv[k][r] = 1'b0; acc_cnt[k][r] = 0;
      end
      mwait[k] = 0; hist[k] = '0;
    end
    mrand = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_req(input int r, input logic rnw, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      rv[k][r] = 1'b1; rrnw[k][r] = rnw; raddr[k][r] = a; rwd[k][r] = d;
    end
  endtask

  initial begin
    rst = 1'b1; mrand = 1'b0; chk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mg[k] = -1; mlast[k] = 1; mwc[k] = 0; mecnt[k] = 0; mcnt[k] = 0; mwait[k] = 0;
      mfix[k] = 32'h0; macc[k] = 1'b0; mrd[k] = '0; hist[k] = '0;
      for (int r = 0; r < 2; r++) begin
        rv[k][r] = 1'b0; rrnw[k][r] = 1'b0; raddr[k][r] = '0; rwd[k][r] = '0; acc_cnt[k][r] = 0;
      end
    end
    @(negedge clk);
    chk_en = 1'b1;
    step();
    check(0, "reset_grant", 32'(ob_gnt[0]), 32'h0);
    check(0, "reset_m_valid", 32'(ob_mv[0]), 32'h0);
    check(1, "reset_err_cnt", 32'(ob_ecnt[1]), 32'h0);
    rst = 1'b0;

    // Zero-wait r0 read
    do_reset();
    mfix[0] = 32'hCAFEF00D; mfix[1] = 32'hCAFEF00D;
    set_req(0, 1'b1, 32'h100, 32'h0);
    step();
    check(0, "t1_idle_m_valid", 32'(ob_mv[0]), 32'h0);
    step();
    check(0, "t1_m_valid", 32'(ob_mv[0]), 32'h1);
    check(0, "t1_r0_accept", 32'(ob_acc[0][0]), 32'h1);
    check(0, "t1_r0_data", ob_rd[0][0], 32'hCAFEF00D);
    check(0, "t1_grant", 32'(ob_gnt[0]), 32'h1);
    check(0, "t1_m_addr", ob_maddr[0], 32'h100);
    rv[0][0] = 1'b0; rv[1][0] = 1'b0;
    step();

    // Both held valid: alternating vs. fixed priority
    do_reset();
    set_req(0, 1'b1, 32'h200, 32'h0);
    set_req(1, 1'b0, 32'h300, 32'h55AA55AA);
    repeat (4) step();
    check(0, "t2_r1_m_data", ob_mwd[0], 32'h55AA55AA);
    repeat (4) step();
    check(0, "t2_rr_grants", 32'(hist[0]), 32'h1212);
    check(1, "t2_fp_grants", 32'(hist[1]), 32'h1111);
    check(0, "t2_rr_r1_accepts", 32'(acc_cnt[0][1]), 32'd2);
    check(1, "t2_fp_r1_accepts", 32'(acc_cnt[1][1]), 32'd0);

    // r1 write with 3 wait states; r0 arrives mid-transfer
    do_reset();
    mwait[0] = 3; mwait[1] = 3;
    set_req(1, 1'b0, 32'h400, 32'h12345678);
    step(); step();
    set_req(0, 1'b1, 32'h500, 32'h0);
    step(); step(); step();
    rv[0][1] = 1'b0; rv[1][1] = 1'b0;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      check(k, "t4_grants", 32'(hist[k][13:0]), 32'h0AA1);
      check(k, "t4_r1_accepts", 32'(acc_cnt[k][1]), 32'd1);
    end

    // Reset during a GNT1 wait
    do_reset();
    mwait[0] = 20; mwait[1] = 20;
    set_req(1, 1'b1, 32'h600, 32'h0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h700, 32'h0);
    step();
    for (int k = 0; k < 2; k++) begin
      check(k, "t6_grant_after_rst", 32'(ob_gnt[k]), 32'h0);
      check(k, "t6_m_valid_after_rst", 32'(ob_mv[k]), 32'h0);
      check(k, "t6_r1_accepts", 32'(acc_cnt[k][1]), 32'd0);
    end
    step();
    for (int k = 0; k < 2; k++) check(k, "t6_tie_to_r0", 32'(ob_gnt[k]), 32'h1);

`ifdef X_MEM_ARB_TIMEOUT_EN
    // Memory never accepts: abort after TO wait cycles
    do_reset();
    mwait[0] = 1000; mwait[1] = 1000; mfix[0] = 32'hDEADBEEF; mfix[1] = 32'hDEADBEEF;
    for (int n = 1; n <= 2; n++) begin
      set_req(0, 1'b1, 32'h800, 32'h0);
      repeat (6) step();
      check(0, "t5_abort_accept", 32'(ob_acc[0][0]), 32'h1);
      check(0, "t5_abort_data", ob_rd[0][0], 32'h0);
      check(0, "t5_err", 32'(ob_err[0]), 32'h1);
      rv[0][0] = 1'b0; rv[1][0] = 1'b0;
      step();
      check(0, "t5_err_cnt", 32'(ob_ecnt[0]), 32'(n));
    end
`endif

    // Randomized traffic against the model
    do_reset();
    mrand = 1'b1;
    mwait[0] = pick_wait(); mwait[1] = pick_wait();
    repeat (4000) begin
      step();
      drive_random();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/x_mem_arb.md
# x_mem_arb

Two-requester arbiter that shares one single-port memory between the rv32i core and a second bus master (debug/DMA). Each requester uses the core's native valid/accept memory protocol. Requests are granted one at a time and forwarded unmodified to the memory side. The accept and read data are routed back to the granted requester only. The block sits between `x_top_rv32i` and the memory model/peripheral fabric.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = requester 0 always wins.
- `TIMEOUT`, default 255: wait cycles before abort (used only with `X_MEM_ARB_TIMEOUT_EN`); legal range 1..255.

Ports:
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_r0_valid` / `i_r0_rnw` input 1 each: requester 0 request and read-not-write.
- `i_r0_addr` / `i_r0_data` input 32 each: requester 0 address and write data.
- `o_r0_accept` output 1: requester 0 transfer complete.
- `o_r0_data` output 32: requester 0 read data.
- `i_r1_*`, `o_r1_*`: requester 1, identical to requester 0.
- `o_m_valid` / `o_m_rnw` output 1 each: memory request and read-not-write.
- `o_m_addr` / `o_m_data` output 32 each: memory address and write data.
- `i_m_accept` input 1: memory transfer complete.
- `i_m_data` input 32: memory read data, valid while `i_m_accept` is high.
- `o_grant` output 2: one-hot current grant; 00 = idle.
- `o_err` output 1: timeout pulse (with `X_MEM_ARB_TIMEOUT_EN` only).
- `o_err_cnt` output 8: saturating timeout count (with `X_MEM_ARB_TIMEOUT_EN` only).

## Operation
- Protocol:
  - A requester holds valid, rnw, addr and data stable until it sees accept.
  - Accept is a single-cycle completion.
  - Read data is sampled by the requester in the accept cycle.
- FSM states are IDLE, GNT0 and GNT1; the reset state is IDLE.
- In IDLE:
  - Only r0 valid → GNT0; only r1 valid → GNT1.
  - Both valid: `FIXED_PRIO`=1 → GNT0. `FIXED_PRIO`=0 → grant the requester that is not `last`.
  - `last` is a 1-bit register, reset to 1, so r0 wins the first tie. It is updated to the granted index on entry to GNTx.
- In GNTx:
  - `o_m_valid = i_rx_valid`; rnw, addr and data are muxed from requester x.
  - `o_rx_accept = i_m_accept & i_rx_valid`, and `o_rx_data = i_m_data`.
  - The non-granted requester sees accept=0 and data=0.
- GNTx → IDLE on `i_m_accept`. GNTx → IDLE on `i_rx_valid` low (requester withdrew; no accept is issued).
- There is no back-to-back grant: IDLE is always visited between transfers, which makes the round-robin decision explicit.
- In IDLE, `o_m_valid` = 0, every `o_*_data` = 0 and `o_grant` = 00.

## Timing
- Reset values: all outputs 0, state IDLE, `last` = 1, `o_err_cnt` = 0.
- Reset asserted mid-transfer: next cycle is IDLE; the outstanding request is dropped, with no accept issued to the requester.
- Latency:
  - Request first seen valid in IDLE at cycle N → `o_m_valid` high at N+1.
  - With a zero-wait memory, `o_rx_accept` at N+1 and the FSM is back in IDLE at N+2.
  - Peak throughput is one transfer per 2 cycles.
  - Memory wait states add one cycle each.
- A request that arrives while the other requester is granted waits in its valid state and is evaluated in the next IDLE cycle.
- All grant/FSM state is registered; the data and accept paths are combinational.

## Configuration
- Macro: `X_MEM_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on GNTx entry and increments in each GNTx cycle without `i_m_accept`.
  - On the cycle when the counter equals `TIMEOUT` with no accept, the arbiter aborts:
    - `o_m_valid` is forced to 0.
    - `o_rx_accept` = 1, `o_rx_data` = 32'h0.
    - `o_err` pulses 1 for that cycle.
    - `o_err_cnt` increments, saturating at 255.
    - Next state is IDLE.
  - A real `i_m_accept` in that same cycle wins: normal completion, no error.
- Not defined: the counter, `o_err` and `o_err_cnt` logic are absent, `o_err`/`o_err_cnt` are tied to 0, and the arbiter waits indefinitely.

## Test plan
- r0 read of addr 0x100, memory zero-wait returning 0xCAFEF00D: `o_m_valid` high 1 cycle after the request, `o_r0_accept` the same cycle, `o_r0_data` = 0xCAFEF00D, `o_grant` = 01.
- Both requesters held valid for 4 transfers, `FIXED_PRIO`=0: grants are r0, r1, r0, r1; IDLE occurs between each; r1 write data 0x55AA55AA appears on `o_m_data` during its grants.
- Same stimulus with `FIXED_PRIO`=1: r0 is granted every time and r1 never sees accept while r0 keeps requesting.
- Memory inserts 3 wait states on an r1 write: `o_m_*` are stable for 4 cycles, `o_r1_accept` pulses once, and r0's valid raised mid-transfer is granted only after the next IDLE.
- With `X_MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=4, memory never accepts: after 4 wait cycles, `o_r0_accept`=1, `o_r0_data`=0, `o_err` pulses, and `o_err_cnt`=1. A second timeout gives `o_err_cnt`=2.
- `i_rst` high during a GNT1 wait: next cycle all outputs are 0, `o_grant`=00, and no `o_r1_accept` is issued. After release, a simultaneous request is granted to r0.
